// File: rtl/prod_arb2.sv
// prod_arb2: two-input round-robin arbiter with a per-input FIFO and a
// registered output stage using a valid/ready handshake.
// Optional feature macro: PROD_ARB_FIXED_PRIO_EN. When defined, channel 0 has
// strict priority. When undefined (the default), the two channels alternate.
module prod_arb2 #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          val0,
    input  logic [DW-1:0] data0,
    input  logic          val1,
    input  logic [DW-1:0] data1,
    input  logic          rdy,
    output logic          val_o,
    output logic [DW-1:0] data_o,
    output logic          src_o,
    output logic          ovf0,
    output logic          ovf1,
    output logic [AW:0]   cnt0,
    output logic [AW:0]   cnt1
);

    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAST0,
        S_LAST1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [AW-1:0] wptr0;
    logic [AW-1:0] rptr0;
    logic [AW-1:0] wptr1;
    logic [AW-1:0] rptr1;

    logic load_ok;
    logic grant;
    logic pop0;
    logic pop1;
    logic push0;
    logic push1;

    // Arbiter state: remembers which channel was popped last.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection, pop/push decisions and next arbiter state.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        pop0      = 1'b0;
        pop1      = 1'b0;
        load_ok   = !val_o || rdy;

        if ((cnt0 != '0) && (cnt1 != '0)) begin
`ifdef PROD_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            // From S_IDLE or S_LAST1 channel 0 goes next.
            grant = (state == S_LAST0);
`endif
        end else begin
            grant = (cnt0 == '0);
        end

        if (load_ok && ((cnt0 != '0) || (cnt1 != '0))) begin
            pop0 = !grant;
            pop1 = grant;
        end

        if (pop0) begin
            state_nxt = S_LAST0;
        end else if (pop1) begin
            state_nxt = S_LAST1;
        end

        // A full FIFO still accepts a word when its head leaves at the same edge.
        push0 = val0 && ((cnt0 != FULL) || pop0);
        push1 = val1 && ((cnt1 != FULL) || pop1);
    end

    // Output stage: load the granted head when free, hold under backpressure.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            val_o  <= 1'b0;
            data_o <= '0;
            src_o  <= 1'b0;
        end else if (load_ok) begin
            if (pop0 || pop1) begin
                val_o  <= 1'b1;
                data_o <= grant ? mem1[rptr1] : mem0[rptr0];
                src_o  <= grant;
            end else begin
                val_o  <= 1'b0;
            end
        end
    end

    // Channel 0 pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wptr0 <= '0;
            rptr0 <= '0;
            cnt0  <= '0;
            ovf0  <= 1'b0;
        end else begin
            if (push0) begin
                wptr0 <= wptr0 + PTR_ONE;
            end
            if (pop0) begin
                rptr0 <= rptr0 + PTR_ONE;
            end
            cnt0 <= cnt0 + (AW+1)'(push0) - (AW+1)'(pop0);
            if (val0 && !push0) begin
                ovf0 <= 1'b1;
            end
        end
    end

    // Channel 1 pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wptr1 <= '0;
            rptr1 <= '0;
            cnt1  <= '0;
            ovf1  <= 1'b0;
        end else begin
            if (push1) begin
                wptr1 <= wptr1 + PTR_ONE;
            end
            if (pop1) begin
                rptr1 <= rptr1 + PTR_ONE;
            end
            cnt1 <= cnt1 + (AW+1)'(push1) - (AW+1)'(pop1);
            if (val1 && !push1) begin
                ovf1 <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem0[wptr0] <= data0;
        end
        if (push1) begin
            mem1[wptr1] <= data1;
        end
    end

endmodule

// File: tb/tb_prod_arb2.sv
// Testbench for prod_arb2: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expected transfer sequences.
module tb_prod_arb2;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          val0 = 1'b0;
    logic [DW-1:0] data0 = '0;
    logic          val1 = 1'b0;
    logic [DW-1:0] data1 = '0;
    logic          rdy = 1'b0;
    logic          val_o;
    logic [DW-1:0] data_o;
    logic          src_o;
    logic          ovf0;
    logic          ovf1;
    logic [AW:0]   cnt0;
    logic [AW:0]   cnt1;

    int errors = 0;
    int checks = 0;

    prod_arb2 #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .val0   (val0),
        .data0  (data0),
        .val1   (val1),
        .data1  (data1),
        .rdy    (rdy),
        .val_o  (val_o),
        .data_o (data_o),
        .src_o  (src_o),
        .ovf0   (ovf0),
        .ovf1   (ovf1),
        .cnt0   (cnt0),
        .cnt1   (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs are queues, the output stage is a single slot.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          m_val  = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          m_src  = 1'b0;
    logic          m_ovf0 = 1'b0;
    logic          m_ovf1 = 1'b0;
    int            last   = -1;
    int            g;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q0.delete();
            q1.delete();
            m_val  = 1'b0;
            m_data = '0;
            m_src  = 1'b0;
            m_ovf0 = 1'b0;
            m_ovf1 = 1'b0;
            last   = -1;
        end else begin
            // Output slot frees up (empty or word taken), then refills.
            if (!m_val || rdy) begin
                if (q0.size() == 0 && q1.size() == 0) begin
                    m_val = 1'b0;
                end else begin
                    if (q1.size() == 0) g = 0;
                    else if (q0.size() == 0) g = 1;
`ifdef PROD_ARB_FIXED_PRIO_EN
                    else g = 0;
`else
                    else g = (last == 0) ? 1 : 0;
`endif
                    m_val = 1'b1;
                    m_src = (g == 1);
                    m_data = (g == 1) ? q1.pop_front() : q0.pop_front();
                    last = g;
                end
            end
            // Producers append after the pop, so a freed slot is usable.
            if (val0) begin
                if (q0.size() < DEPTH) q0.push_back(data0);
                else m_ovf0 = 1'b1;
            end
            if (val1) begin
                if (q1.size() < DEPTH) q1.push_back(data1);
                else m_ovf1 = 1'b1;
            end
        end
    end

    // Transfers observed from the DUT: {src, data}, one entry per accepted word.
    logic [8:0] dut_log[$];
    logic [8:0] exp_log[$];

    // Every-cycle comparison against the model; also records transfers.
    always @(negedge clk) begin
        chk("val_o",  32'(val_o),  32'(m_val));
        chk("data_o", 32'(data_o), 32'(m_data));
        chk("src_o",  32'(src_o),  32'(m_src));
        chk("ovf0",   32'(ovf0),   32'(m_ovf0));
        chk("ovf1",   32'(ovf1),   32'(m_ovf1));
        chk("cnt0",   32'(cnt0),   32'(q0.size()));
        chk("cnt1",   32'(cnt1),   32'(q1.size()));
        if (rst_b && val_o && rdy) dut_log.push_back({src_o, data_o});
    end

    task automatic step(input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1, input logic r);
        val0  = v0;
        data0 = d0;
        val1  = v1;
        data1 = d1;
        rdy   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        val0  = 1'b0;
        val1  = 1'b0;
        rdy   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        dut_log.delete();
        rst_b = 1'b1;
    endtask

    task automatic check_log(input string name);
        logic [8:0] act;
        chk({name, "_len"}, 32'(dut_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size(); i++) begin
            act = (i < dut_log.size()) ? dut_log[i] : 9'h1FF;
            chk(name, 32'(act), 32'(exp_log[i]));
        end
    endtask

    initial begin
        // Reset with both producers active: nothing may be captured.
        rst_b = 1'b0;
        val0 = 1'b1; data0 = 8'hEE;
        val1 = 1'b1; data1 = 8'hEF;
        rdy  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_val_o", 32'(val_o), 32'd0);
        chk("rst_cnt0",  32'(cnt0),  32'd0);
        chk("rst_cnt1",  32'(cnt1),  32'd0);
        chk("rst_ovf",   32'({ovf0, ovf1}), 32'd0);
        rst_b = 1'b1;
        step(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
        chk("lat_edge1_val", 32'(val_o), 32'd0);
        chk("lat_edge1_cnt0", 32'(cnt0), 32'd1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("lat_edge2_val", 32'(val_o), 32'd1);
        chk("lat_edge2_data", 32'(data_o), 32'h55);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("lat_edge3_val", 32'(val_o), 32'd0);

        // Single channel stream.
        do_reset();
        step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h12, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h13, 1'b0, 8'h00, 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("single_cnt1", 32'(cnt1), 32'd0);
        exp_log = '{9'h011, 9'h012, 9'h013};
        check_log("single");

        // Fairness with both FIFOs preloaded.
        do_reset();
        step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0);
        step(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("rr_pre_data", 32'(data_o), 32'hA0);
        chk("rr_pre_cnt0", 32'(cnt0), 32'd1);
        chk("rr_pre_cnt1", 32'(cnt1), 32'd2);
        repeat (6) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
`ifdef PROD_ARB_FIXED_PRIO_EN
        exp_log = '{9'h0A0, 9'h0A1, 9'h1B0, 9'h1B1};
`else
        exp_log = '{9'h0A0, 9'h1B0, 9'h0A1, 9'h1B1};
`endif
        check_log("rr_order");

        // Overflow on channel 1: the output slot takes 0x01, FIFO holds 0x02..0x05.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b0, 8'h00, 1'b1, 8'(i), 1'b0);
        chk("ovf_cnt1_5", 32'(cnt1), 32'd4);
        chk("ovf_flag_5", 32'(ovf1), 32'd0);
        step(1'b0, 8'h00, 1'b1, 8'h06, 1'b0);
        chk("ovf_cnt1_6", 32'(cnt1), 32'd4);
        chk("ovf_flag_6", 32'(ovf1), 32'd1);
        chk("ovf_ovf0", 32'(ovf0), 32'd0);
        repeat (7) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        exp_log = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h105};
        check_log("ovf_drain");
        chk("ovf_sticky", 32'(ovf1), 32'd1);

        // Backpressure hold.
        do_reset();
        step(1'b1, 8'h2A, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            chk("bp_val", 32'(val_o), 32'd1);
            chk("bp_data", 32'(data_o), 32'h2A);
            chk("bp_src", 32'(src_o), 32'd0);
        end
        repeat (3) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        exp_log = '{9'h02A};
        check_log("bp_once");

        // Push into a full FIFO at the same edge as its pop.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 8'h00, 1'b0);
        chk("full_cnt0", 32'(cnt0), 32'd4);
        chk("full_head", 32'(data_o), 32'h10);
        step(1'b1, 8'h15, 1'b0, 8'h00, 1'b1);
        chk("full_pp_cnt0", 32'(cnt0), 32'd4);
        chk("full_pp_ovf0", 32'(ovf0), 32'd0);
        chk("full_pp_data", 32'(data_o), 32'h11);
        repeat (6) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        exp_log = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014, 9'h015};
        check_log("full_drain");

        // Reset mid-operation discards buffered words.
        do_reset();
        step(1'b1, 8'h31, 1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h32, 1'b1, 8'h42, 1'b0);
        rst_b = 1'b0;
        #1;
        chk("mid_rst_val", 32'(val_o), 32'd0);
        chk("mid_rst_cnt0", 32'(cnt0), 32'd0);
        chk("mid_rst_cnt1", 32'(cnt1), 32'd0);
        @(posedge clk);
        #1;
        dut_log.delete();
        rst_b = 1'b1;
        repeat (3) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("mid_rst_log", 32'(dut_log.size()), 32'd0);

        // Mixed traffic, checked only by the per-cycle model comparison.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end
        repeat (8) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
